wah_coeff_sequencer: RTL and testbench

Controller for the wah biquad coefficient path, clocked on system_clock (96 MHz).
- Detects each sample tick from the clock divider.
- Launches one coefficient calculation per tick, with a start/ready handshake to coefficient_unit.
- Captures the results into a shadow bank.
- Commits that bank atomically to filter_pipeline on the next tick, so the filter never sees a half-updated coefficient set.
- Replaces the ad-hoc start/ready logic in the wah top level. Flags overruns and timeouts.

---
 rtl/wah_pkg.sv | 29 ++
 rtl/wah_coeff_sequencer_if.sv | 37 +++
 rtl/wah_tick_detect.sv | 23 ++
 rtl/wah_coeff_sequencer.sv | 160 ++++++++++++++++
 tb/tb_wah_coeff_sequencer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/wah_pkg.sv
// wah_pkg: shared types and constants for the wah coefficient path.
//   seq_state_t  - sequencer FSM states
//   COEFF_UNITY  - 1.0 in Q8.16, used for the passthrough reset bank
//   IDX_*        - field positions inside a packed 6-coefficient bus
//   get_coeff    - extracts one field from a packed bus
package wah_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } seq_state_t;

   localparam int COEFF_W = 24;
   localparam logic [COEFF_W-1:0] COEFF_UNITY = 24'h010000;

   localparam int IDX_B0 = 0;
   localparam int IDX_B1 = 1;
   localparam int IDX_B2 = 2;
   localparam int IDX_A0 = 3;
   localparam int IDX_A1 = 4;
   localparam int IDX_A2 = 5;

   function automatic logic [COEFF_W-1:0] get_coeff(input logic [6*COEFF_W-1:0] bus,
                                                    input int idx);
      return bus[idx*COEFF_W +: COEFF_W];
   endfunction

endpackage

// File: rtl/wah_coeff_sequencer_if.sv
// wah_coeff_sequencer_if: bundles the sequencer's tick, handshake, coefficient
// and status signals.
//   master : the sequencer (drives calc_start, coeff_out, pulses, flags)
//   slave  : the surroundings (drive sample_tick_in, clear_flags, calc_ready, coeff_in)
// Optional overrun_count exists only when WAH_OVERRUN_CNT_EN is defined.
interface wah_coeff_sequencer_if #(parameter int SAMPLE_WIDTH = 24) ();

   logic                        sample_tick_in;
   logic                        clear_flags;
   logic                        calc_start;
   logic                        calc_ready;
   logic [6*SAMPLE_WIDTH-1:0]   coeff_in;
   logic [6*SAMPLE_WIDTH-1:0]   coeff_out;
   logic                        commit_pulse;
   logic                        ready_out;
   logic                        busy;
   logic                        timeout_flag;
   logic                        overrun_flag;
`ifdef WAH_OVERRUN_CNT_EN
   logic [7:0]                  overrun_count;

   modport master (input  sample_tick_in, clear_flags, calc_ready, coeff_in,
                   output calc_start, coeff_out, commit_pulse, ready_out, busy,
                          timeout_flag, overrun_flag, overrun_count);
   modport slave  (output sample_tick_in, clear_flags, calc_ready, coeff_in,
                   input  calc_start, coeff_out, commit_pulse, ready_out, busy,
                          timeout_flag, overrun_flag, overrun_count);
`else
   modport master (input  sample_tick_in, clear_flags, calc_ready, coeff_in,
                   output calc_start, coeff_out, commit_pulse, ready_out, busy,
                          timeout_flag, overrun_flag);
   modport slave  (output sample_tick_in, clear_flags, calc_ready, coeff_in,
                   input  calc_start, coeff_out, commit_pulse, ready_out, busy,
                          timeout_flag, overrun_flag);
`endif

endinterface

// File: rtl/wah_tick_detect.sv
// wah_tick_detect: rising-edge detector for the divided sample clock level.
//   system_clock, rst  - clock, async active-high reset (clears the history flop)
//   sample_tick_in     - sample clock level, synchronous to system_clock
//   tick_rise          - high in the cycle where sample_tick_in is 1 and was 0
module wah_tick_detect (
   input  logic system_clock,
   input  logic rst,
   input  logic sample_tick_in,
   output logic tick_rise
);

   logic tick_q, tick_d;

   always_comb tick_d = sample_tick_in;

   always_ff @(posedge system_clock or posedge rst) begin
      if (rst) tick_q <= 1'b0;
      else     tick_q <= tick_d;
   end

   assign tick_rise = sample_tick_in & ~tick_q;

endmodule

// File: rtl/wah_coeff_sequencer.sv
// wah_coeff_sequencer: launches one coefficient calculation per sample tick,
// captures the result into a shadow bank and commits that bank to the filter
// as a whole on the following tick.
//   system_clock, rst - clock, async active-high reset
//   bus (master)      - tick/clear inputs, calc_start/calc_ready handshake,
//                       coeff_in/coeff_out banks, commit_pulse, ready_out,
//                       busy, sticky timeout_flag / overrun_flag
// Optional: define WAH_OVERRUN_CNT_EN to add the saturating overrun_count.
module wah_coeff_sequencer
   import wah_pkg::*;
#(
   parameter int SAMPLE_WIDTH   = 24,
   parameter int TIMEOUT_CYCLES = 900,
   parameter int TMR_WIDTH      = 10
) (
   input  logic system_clock,
   input  logic rst,
   wah_coeff_sequencer_if.master bus
);

   localparam int BW = 6*SAMPLE_WIDTH;
   localparam logic [BW-1:0] UNITY_BANK =
      BW'(COEFF_UNITY) | (BW'(COEFF_UNITY) << (IDX_A0*SAMPLE_WIDTH));
   localparam logic [TMR_WIDTH-1:0] TMO_LAST = TMR_WIDTH'(TIMEOUT_CYCLES - 1);

   logic tick_rise;

   wah_tick_detect u_tick (
      .system_clock   (system_clock),
      .rst            (rst),
      .sample_tick_in (bus.sample_tick_in),
      .tick_rise      (tick_rise)
   );

   seq_state_t           state_q, state_d;
   logic [TMR_WIDTH-1:0] timer_q, timer_d;
   logic [BW-1:0]        shadow_q, shadow_d;
   logic [BW-1:0]        coeff_q, coeff_d;
   logic                 shadow_valid_q, shadow_valid_d;
   logic                 commit_pend_q, commit_pend_d;
   logic                 commit_pulse_q, commit_pulse_d;
   logic                 calc_start_q, calc_start_d;
   logic                 ready_out_q, ready_out_d;
   logic                 busy_q, busy_d;
   logic                 timeout_q, timeout_d;
   logic                 overrun_q, overrun_d;
   logic                 overrun_evt, timeout_evt;

   always_comb begin
      state_d        = state_q;
      timer_d        = timer_q;
      shadow_d       = shadow_q;
      coeff_d        = coeff_q;
      shadow_valid_d = shadow_valid_q;
      commit_pend_d  = 1'b0;
      ready_out_d    = 1'b0;
      timeout_evt    = 1'b0;
      // Pulses trail their cause by one edge so they line up with the
      // cycle after the state/bank change.
      calc_start_d   = (state_q == START);
      commit_pulse_d = commit_pend_q;

      case (state_q)
         IDLE: begin
            if (tick_rise) begin
               if (shadow_valid_q) begin
                  coeff_d        = shadow_q;
                  shadow_valid_d = 1'b0;
                  commit_pend_d  = 1'b1;
               end
               state_d = START;
            end
         end
         START: begin
            timer_d = '0;
            state_d = WAIT;
         end
         WAIT: begin
            timer_d = timer_q + TMR_WIDTH'(1);
            // ready has priority over a coincident timeout
            if (bus.calc_ready) begin
               shadow_d       = bus.coeff_in;
               shadow_valid_d = 1'b1;
               ready_out_d    = 1'b1;
               state_d        = IDLE;
            end else if (timer_q == TMO_LAST) begin
               timeout_evt = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A tick while busy is dropped; only the flag records it.
      overrun_evt = tick_rise && (state_q != IDLE);
      busy_d      = (state_d != IDLE);
      timeout_d   = timeout_evt | (timeout_q & ~bus.clear_flags);
      overrun_d   = overrun_evt | (overrun_q & ~bus.clear_flags);
   end

   always_ff @(posedge system_clock or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         timer_q        <= '0;
         shadow_q       <= UNITY_BANK;
         coeff_q        <= UNITY_BANK;
         shadow_valid_q <= 1'b0;
         commit_pend_q  <= 1'b0;
         commit_pulse_q <= 1'b0;
         calc_start_q   <= 1'b0;
         ready_out_q    <= 1'b0;
         busy_q         <= 1'b0;
         timeout_q      <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         timer_q        <= timer_d;
         shadow_q       <= shadow_d;
         coeff_q        <= coeff_d;
         shadow_valid_q <= shadow_valid_d;
         commit_pend_q  <= commit_pend_d;
         commit_pulse_q <= commit_pulse_d;
         calc_start_q   <= calc_start_d;
         ready_out_q    <= ready_out_d;
         busy_q         <= busy_d;
         timeout_q      <= timeout_d;
         overrun_q      <= overrun_d;
      end
   end

   assign bus.calc_start   = calc_start_q;
   assign bus.coeff_out    = coeff_q;
   assign bus.commit_pulse = commit_pulse_q;
   assign bus.ready_out    = ready_out_q;
   assign bus.busy         = busy_q;
   assign bus.timeout_flag = timeout_q;
   assign bus.overrun_flag = overrun_q;

`ifdef WAH_OVERRUN_CNT_EN
   logic [7:0] ovr_cnt_q, ovr_cnt_d;

   // Coincident overrun and timeout count once; increment beats clear.
   always_comb begin
      ovr_cnt_d = ovr_cnt_q;
      if (overrun_evt || timeout_evt) begin
         if (ovr_cnt_q != 8'hFF) ovr_cnt_d = ovr_cnt_q + 8'd1;
      end else if (bus.clear_flags) begin
         ovr_cnt_d = 8'h00;
      end
   end

   always_ff @(posedge system_clock or posedge rst) begin
      if (rst) ovr_cnt_q <= 8'h00;
      else     ovr_cnt_q <= ovr_cnt_d;
   end

   assign bus.overrun_count = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_wah_coeff_sequencer.sv
module tb_wah_coeff_sequencer;
   import wah_pkg::*;

   localparam int SW  = 24;
   localparam int TMO = 900;
   localparam logic [143:0] UNITY = 144'h000000_000000_010000_000000_000000_010000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wah_coeff_sequencer_if #(.SAMPLE_WIDTH(SW)) bus ();

   wah_coeff_sequencer #(.SAMPLE_WIDTH(SW), .TIMEOUT_CYCLES(TMO), .TMR_WIDTH(10)) dut (
      .system_clock (clk),
      .rst          (rst),
      .bus          (bus)
   );

   int errors = 0;
   int checks = 0;
   int shown  = 0;

   task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (shown < 30) begin
            shown++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
         end
      end
   endtask

   function automatic logic [143:0] pack(input logic [23:0] b0, b1, b2, a0, a1, a2);
      return {a2, a1, a0, b2, b1, b0};
   endfunction

   // ---------------- behavioural model ----------------
   // Tracks the launch edge of the current calculation and derives every
   // output from elapsed edges since launch.
   bit            prev_tick, m_busy, m_sv, m_commit_next;
   bit            m_start_p, m_commit_p, m_ready_p, m_tflag, m_oflag;
   logic [143:0]  m_coeff, m_shadow;
   int            e, launch_e;
`ifdef WAH_OVERRUN_CNT_EN
   int            m_cnt;
`endif

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_tick = 0; m_busy = 0; m_sv = 0; m_commit_next = 0;
         m_start_p = 0; m_commit_p = 0; m_ready_p = 0; m_tflag = 0; m_oflag = 0;
         m_coeff = UNITY; m_shadow = UNITY; e = 0; launch_e = 0;
`ifdef WAH_OVERRUN_CNT_EN
         m_cnt = 0;
`endif
      end else begin
         bit rise, ovr, tmo;
         e++;
         rise = bus.sample_tick_in && !prev_tick;
         prev_tick = bus.sample_tick_in;
         ovr = 0; tmo = 0;
         m_start_p  = m_busy && (e == launch_e + 1);
         m_commit_p = m_commit_next;
         m_commit_next = 0;
         m_ready_p  = 0;
         if (m_busy) begin
            if (rise) ovr = 1;
            if (e >= launch_e + 2) begin
               if (bus.calc_ready) begin
                  m_shadow = bus.coeff_in; m_sv = 1; m_ready_p = 1; m_busy = 0;
               end else if (e - launch_e == TMO + 1) begin
                  tmo = 1; m_busy = 0;
               end
            end
         end else if (rise) begin
            if (m_sv) begin m_coeff = m_shadow; m_sv = 0; m_commit_next = 1; end
            m_busy = 1; launch_e = e;
         end
         m_tflag = tmo || (m_tflag && !bus.clear_flags);
         m_oflag = ovr || (m_oflag && !bus.clear_flags);
`ifdef WAH_OVERRUN_CNT_EN
         if (ovr || tmo) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
         else if (bus.clear_flags) m_cnt = 0;
`endif
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("coeff_out",    bus.coeff_out,            m_coeff);
         chk("calc_start",   144'(bus.calc_start),     144'(m_start_p));
         chk("commit_pulse", 144'(bus.commit_pulse),   144'(m_commit_p));
         chk("ready_out",    144'(bus.ready_out),      144'(m_ready_p));
         chk("busy",         144'(bus.busy),           144'(m_busy));
         chk("timeout_flag", 144'(bus.timeout_flag),   144'(m_tflag));
         chk("overrun_flag", 144'(bus.overrun_flag),   144'(m_oflag));
`ifdef WAH_OVERRUN_CNT_EN
         chk("overrun_count", 144'(bus.overrun_count), 144'(m_cnt));
`endif
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick_pulse();
      @(posedge clk); #2 bus.sample_tick_in = 1'b1;
      @(posedge clk);
      @(posedge clk); #2 bus.sample_tick_in = 1'b0;
   endtask

   task automatic wait_start(input string nm);
      bit seen = 0;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clk);
         if (bus.calc_start) seen = 1;
      end
      chk(nm, 144'(seen), 144'(1));
   endtask

   task automatic pulse_ready(input logic [143:0] c, input bit exp_rdy);
      @(posedge clk); #2 bus.coeff_in = c; bus.calc_ready = 1'b1;
      @(posedge clk); #2 bus.calc_ready = 1'b0;
      @(negedge clk);
      chk("ready_out_pulse", 144'(bus.ready_out), 144'(exp_rdy));
   endtask

   task automatic pulse_clear();
      @(posedge clk); #2 bus.clear_flags = 1'b1;
      @(posedge clk); #2 bus.clear_flags = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t required below 2000000", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit done;
      bus.sample_tick_in = 0; bus.clear_flags = 0; bus.calc_ready = 0; bus.coeff_in = '0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("reset_coeff_out", bus.coeff_out, UNITY);
      chk("reset_flags", 144'({bus.calc_start, bus.commit_pulse, bus.ready_out, bus.busy,
                               bus.timeout_flag, bus.overrun_flag}), 144'(0));

      // normal calc: ready 20 cycles after start, commit on next tick
      tick_pulse(); wait_start("start_1");
      repeat (20) @(posedge clk);
      pulse_ready(pack(24'h00C000, 24'h000100, 24'h000200, 24'h010000, 24'hFF8000, 24'h004000), 1);
      chk("no_commit_before_tick", bus.coeff_out, UNITY);
      tick_pulse(); wait_start("start_2");
      chk("commit_b0_C000", 144'(get_coeff(bus.coeff_out, IDX_B0)), 144'(24'h00C000));
      chk("commit_pulse_2", 144'(bus.commit_pulse), 144'(1));
      repeat (5) @(posedge clk);
      pulse_ready(pack(24'h00A000, 24'h000011, 24'h000022, 24'h010000, 24'h000033, 24'h000044), 1);

      // timeout: commits A000, then never answers
      tick_pulse(); wait_start("start_3");
      chk("commit_b0_A000", 144'(get_coeff(bus.coeff_out, IDX_B0)), 144'(24'h00A000));
      n = 0; done = 0;
      while (!done && n < 1000) begin
         @(negedge clk); n++;
         if (bus.timeout_flag) done = 1;
      end
      chk("timeout_latency", 144'(n), 144'(900));
      chk("busy_after_timeout", 144'(bus.busy), 144'(0));
      tick_pulse(); wait_start("start_4");
      chk("no_commit_after_timeout", 144'(bus.commit_pulse), 144'(0));
      chk("coeff_kept", bus.coeff_out,
          pack(24'h00A000, 24'h000011, 24'h000022, 24'h010000, 24'h000033, 24'h000044));

      // overrun: second tick 500 cycles in, ready ~600 cycles in
      repeat (500) @(posedge clk);
      tick_pulse();
      @(negedge clk);
      chk("overrun_set", 144'(bus.overrun_flag), 144'(1));
      repeat (90) @(posedge clk);
      pulse_ready(pack(24'h00B000, 24'h0, 24'h0, 24'h010000, 24'h0, 24'h0), 1);
      chk("timeout_sticky", 144'(bus.timeout_flag), 144'(1));

      pulse_clear();
      chk("flags_cleared", 144'({bus.timeout_flag, bus.overrun_flag}), 144'(0));

      // reset during WAIT; later ready ignored
      tick_pulse(); wait_start("start_5");
      chk("commit_b0_B000", 144'(get_coeff(bus.coeff_out, IDX_B0)), 144'(24'h00B000));
      repeat (10) @(posedge clk);
      #2 rst = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      pulse_ready(pack(24'h00D000, 24'h0, 24'h0, 24'h010000, 24'h0, 24'h0), 0);
      chk("unity_after_reset", bus.coeff_out, UNITY);
      chk("idle_after_reset", 144'(bus.busy), 144'(0));

      // overrun burst: 300 dropped ticks then a timeout
      tick_pulse(); wait_start("start_6");
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #2 bus.sample_tick_in = 1'b1;
         @(posedge clk); #2 bus.sample_tick_in = 1'b0;
      end
      n = 0; done = 0;
      while (!done && n < 1200) begin
         @(negedge clk); n++;
         if (!bus.busy) done = 1;
      end
      chk("burst_ends", 144'(done), 144'(1));
      chk("burst_flags", 144'({bus.timeout_flag, bus.overrun_flag}), 144'(2'b11));
`ifdef WAH_OVERRUN_CNT_EN
      chk("count_saturated", 144'(bus.overrun_count), 144'(8'hFF));
`endif
      pulse_clear();
      chk("burst_cleared", 144'({bus.timeout_flag, bus.overrun_flag}), 144'(0));
`ifdef WAH_OVERRUN_CNT_EN
      chk("count_cleared", 144'(bus.overrun_count), 144'(0));
`endif

      repeat (5) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
